// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants and coefficient type, reused by the NTT
// controller, the modular add/sub stages and the Barrett reducer.
package kyber_pkg;

  localparam int KYBER_Q   = 3329;
  localparam int BARRETT_K = 24;
  localparam int BARRETT_M = (2 ** BARRETT_K) / KYBER_Q;  // 5039

  typedef logic [11:0] coeff_t;

endpackage

// File: rtl/kyber_barrett_reduce_if.sv
// Valid/ready stream bundle around the Barrett reducer: product in, coefficient
// out, plus the multiplier clock enable that mirrors in_ready.
interface kyber_barrett_reduce_if #(
  parameter int W_IN  = 24,
  parameter int W_OUT = 12
) ();

  logic             in_valid;
  logic [W_IN-1:0]  in_data;
  logic             in_ready;
  logic             mult_ce;
  logic             out_valid;
  logic [W_OUT-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, mult_ce, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, mult_ce, out_valid, out_data
  );

endinterface

// File: rtl/kyber_cond_sub.sv
// Final correction step shared by modular add/sub and reduction:
// maps r in [0, 2Q) to r mod Q.
module kyber_cond_sub
  import kyber_pkg::*;
#(
  parameter int Q = KYBER_Q
) (
  input  logic [12:0] r,
  output coeff_t      y
);

  always_comb begin
    y = r[11:0];
    if (r >= 13'(Q)) begin
      y = 12'(r - 13'(Q));
    end
  end

endmodule

// File: rtl/kyber_barrett_reduce.sv
// Three-stage Barrett reducer: 24-bit product in, canonical coefficient mod Q out.
// The pipeline is a rigid shift that freezes as a whole while the output is stalled.
module kyber_barrett_reduce
  import kyber_pkg::*;
#(
  parameter int Q     = KYBER_Q,
  parameter int W_IN  = BARRETT_K,
  parameter int W_OUT = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  kyber_barrett_reduce_if.slave bus
);

  localparam int unsigned M_VAL = (2 ** W_IN) / Q;
  localparam int          T_W   = $clog2(M_VAL + 1);
  localparam int          P_W   = W_IN + T_W;
  localparam int          R_W   = W_OUT + 1;

  // Quotient estimate t = floor(x*M / 2^k); never exceeds the true quotient by more than 0
  // and undershoots it by at most 1, so x - t*Q lies in [0, 2Q).
  function automatic logic [T_W-1:0] barrett_quot(input logic [W_IN-1:0] x);
    return T_W'((P_W'(x) * P_W'(M_VAL)) >> W_IN);
  endfunction

  // Since the remainder is below 2Q < 2^R_W, the low R_W bits of the difference are exact.
  function automatic logic [R_W-1:0] barrett_rem(input logic [R_W-1:0] x_lo,
                                                 input logic [T_W-1:0] t);
    return x_lo - R_W'(int'(t) * Q);
  endfunction

  logic             stall;
  logic             accept;

  logic             vld_p0;
  logic [R_W-1:0]   x_p0;
  logic [T_W-1:0]   t_p0;
  logic             vld_p1;
  logic [R_W-1:0]   r_p1;
  logic             vld_p2;
  logic [W_OUT-1:0] y_p2;
  coeff_t           y_nxt;

  assign stall  = vld_p2 & ~bus.out_ready;
  assign accept = bus.in_valid & ~stall;

  kyber_cond_sub #(.Q(Q)) u_cond_sub (
    .r (r_p1),
    .y (y_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      x_p0   <= '0;
      t_p0   <= '0;
      vld_p1 <= 1'b0;
      r_p1   <= '0;
      vld_p2 <= 1'b0;
      y_p2   <= '0;
    end else if (!stall) begin
      // p0: accept product, form quotient estimate
      vld_p0 <= accept;
      x_p0   <= bus.in_data[R_W-1:0];
      t_p0   <= barrett_quot(bus.in_data);
      // p1: partial remainder in [0, 2Q)
      vld_p1 <= vld_p0;
      r_p1   <= barrett_rem(x_p0, t_p0);
      // p2: canonical coefficient
      vld_p2 <= vld_p1;
      y_p2   <= W_OUT'(y_nxt);
    end
  end

  assign bus.in_ready  = ~stall;
  assign bus.mult_ce   = ~stall;
  assign bus.out_valid = vld_p2;
  assign bus.out_data  = y_p2;

endmodule

// File: tb/tb_kyber_barrett_reduce.sv
// Directed and randomized checks of the Barrett reducer against plain x mod 3329.
module tb_kyber_barrett_reduce;

  localparam int Q = 3329;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  kyber_barrett_reduce_if #(.W_IN(24), .W_OUT(12)) bus ();

  kyber_barrett_reduce dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated product: result must appear in the third cycle after the accept cycle.
  task automatic send_one(input string tag, input logic [23:0] x, input logic [11:0] exp);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_lat2"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.out_data), 32'(exp));
    tick();
    chk({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [23:0] dir_x   [6];
    logic [11:0] dir_exp [6];
    logic [11:0] exp_q   [$];
    logic [23:0] x;
    int          n_out;

    n_vec = 0;
    n_bad = 0;
    dir_x   = '{24'd0, 24'd3328, 24'd3329, 24'd6657, 24'd11075584, 24'd16777215};
    dir_exp = '{12'd0, 12'd3328, 12'd0,    12'd3328, 12'd1,        12'd2384};

    // Reset state
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mult_ce", 32'(bus.mult_ce), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

    // Directed values and extremes
    for (int i = 0; i < 6; i++) begin
      send_one($sformatf("dir%0d", i), dir_x[i], dir_exp[i]);
    end

    // Back-to-back random stream with out_ready held high
    n_out = 0;
    for (int i = 0; i < 1004; i++) begin
      if (i < 1000) begin
        case (i % 50)
          0:       x = 24'hFFFFFF;
          1:       x = 24'd0;
          default: x = 24'($urandom_range(0, 24'hFFFFFF));
        endcase
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        exp_q.push_back(12'(int'(x) % Q));
        chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (i >= 2 && i <= 1001) begin
        chk("stream_valid", 32'(bus.out_valid), 32'd1);
      end
      if (bus.out_valid && exp_q.size() > 0) begin
        chk("stream_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        n_out++;
      end
    end
    chk("stream_count", 32'(n_out), 32'd1000);
    chk("stream_left", 32'(exp_q.size()), 32'd0);

    // Back-pressure: 1..4, stall 5 cycles once the first result shows
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 24'd1;
    tick();
    bus.in_data = 24'd2;
    tick();
    bus.in_data = 24'd3;
    tick();
    chk("bp_first_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_first_data", 32'(bus.out_data), 32'd1);
    bus.in_data   = 24'd4;
    bus.out_ready = 1'b0;
    #1;
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_mult_ce", 32'(bus.mult_ce), 32'd0);
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_data", 32'(bus.out_data), 32'd1);
      chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_mult_ce", 32'(bus.mult_ce), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      chk("bp_seq_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_seq_data", 32'(bus.out_data), 32'(k));
      tick();
    end
    chk("bp_end_valid", 32'(bus.out_valid), 32'd0);

    // Reset with three values in flight
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 24'($urandom_range(0, 24'hFFFFFF));
      tick();
    end
    bus.in_valid = 1'b0;
    chk("mid_pre_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.out_data), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_stale", 32'(bus.out_valid), 32'd0);
    end
    x = 24'($urandom_range(0, 24'hFFFFFF));
    send_one("mid_next", x, 12'(int'(x) % Q));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/kyber_barrett_reduce.md
# kyber_barrett_reduce

Pipelined modular reducer that consumes the 24-bit unsigned product of the Kyber 12×12 coefficient multiplier and returns `x mod q`, q = 3329, as a canonical 12-bit coefficient. It sits directly downstream of the multiplier in the NTT butterfly / pointwise-multiply datapath. It carries a valid/ready handshake so back-pressure from the butterfly adder can stall both this block and, through `mult_ce`, the upstream multiplier.

## Interface
- `Q`, 3329, modulus. The pipeline is verified only for 3329.
- `W_IN`, 24, product width; Barrett shift k = W_IN.
- `W_OUT`, 12, coefficient width.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `in_valid`  in  1  `in_data` holds a product this cycle.
- `in_data`  in  W_IN  unsigned product x, any value 0..2^24−1.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `mult_ce`  out  1  clock enable for the upstream multiplier; equals `in_ready`.
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  W_OUT  x mod Q, range 0..3328.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.

## Operation
- Constant M = floor(2^24 / 3329) = 5039 (13 bits). The remainder term 2385 keeps the estimate error below 2.
- Stage S1 (accept): register x; compute `p1 = x * M` (37 bits). Take `t = p1[36:24]`; t ≤ 5039 fits in 13 bits. Register t and x.
- Stage S2: compute `r = x − t*Q` in 24 bits. Guaranteed 0 ≤ r < 2Q, so keep `r[12:0]` and register it.
- Stage S3: if r ≥ Q, output r − Q; otherwise output r. Register the result into `out_data`.
- Each stage has a valid bit (v1, v2, v3); `out_valid` = v3.
- Stall: `stall = v3 & ~out_ready`. When `stall` is high, every stage register and valid bit holds.
- `in_ready = ~stall`. A transfer occurs when `in_valid & in_ready`; v1 loads `in_valid & in_ready`.
- Bubbles do not collapse. The pipeline is a rigid shift, gated only by `stall`, for simplicity and timing.
- No arithmetic overflow is possible for any 24-bit input, including values above (Q−1)^2.

## Timing
- Reset (async assert, sync release): v1 = v2 = v3 = 0, `out_valid` = 0, `out_data` = 0. Data registers are cleared to 0.
- `in_ready` and `mult_ce` read 1 during and after reset, because `stall` = 0.
- Latency: a product accepted at edge N appears with `out_valid` = 1 after edge N+3, when there is no stall.
- Throughput: one result per cycle with `out_ready` held high.
- `in_ready` is combinational from `out_ready` and v3; there is no combinational path from `in_valid` to any output.
- Simultaneous accept and stall cannot occur, because `in_ready` = 0 during a stall.
- `out_data` and `out_valid` are stable while `out_valid & ~out_ready`.
- Reset asserted mid-operation: all in-flight results are discarded immediately and nothing is emitted after release.
- Overall pipeline: multiplier (2 cycles, gated by `mult_ce`) plus this block (3 cycles) gives 5 cycles from operands to reduced coefficient.

## Structure
- The shared Kyber package `kyber_pkg` holds `KYBER_Q = 3329`, `BARRETT_M = 5039`, `BARRETT_K = 24`, and a 12-bit coefficient typedef `coeff_t`. The NTT controller and the adder/subtractor stages reuse these.
- One sub-module is natural: `kyber_cond_sub`, a combinational r ≥ Q ? r−Q : r. The modular add/sub stages reuse it.
- The constant multiplies (×5039, ×3329) are written as shift-add or inferred `*`. They do not need a DSP primitive.

## Test plan
- Single-value checks with `out_ready` = 1, each result 3 cycles after accept:
  - x = 0 → 0
  - x = 3328 → 3328
  - x = 3329 → 0
  - x = 6657 → 3328
- Extremes: x = 11075584 (3328²) → 1; x = 16777215 → 2384. This confirms that r < 2Q holds at full range.
- Streaming: 1000 back-to-back random 24-bit inputs with `out_ready` = 1. Expect one output per cycle, in order, each equal to x mod 3329. `in_ready` stays 1 throughout.
- Back-pressure: stream x = 1, 2, 3, 4 and hold `out_ready` = 0 for 5 cycles once `out_valid` rises.
  - `out_data` holds at 1.
  - `in_ready` = `mult_ce` = 0 for the whole stall.
  - After release, 2, 3, 4 follow on consecutive cycles with no loss or duplication.
- Reset mid-stream: assert `rst_n` = 0 asynchronously with 3 values in flight.
  - `out_valid` drops immediately.
  - After release, no stale outputs appear and the next input is reduced correctly.
